// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single-ported unified memory between the core's
//                instruction-fetch port (imem) and load/store port (dmem).
//                Runs one memory transaction at a time, returns each response
//                to the requester that issued it, and generates the core-wide
//                stall signal.
//
//  Ports
//    clk, reset              : clock (rising edge), asynchronous active-low reset
//    imem_req_* / imem_resp_*: fetch request (held until response) / response
//    dmem_req_* / dmem_resp_*: load/store request (held until response) / response
//    mem_req_* / mem_resp_*  : request/response channel to the memory model
//    stall                   : combinational; core holds state while asserted
//    wdog_err                : sticky watchdog timeout flag
//
//  Optional feature
//    MEM_ARB_WATCHDOG_EN : when defined, a per-state cycle counter aborts a
//                          REQ/WAIT that lasts WDOG_LIMIT cycles, sets wdog_err
//                          and releases the owner with 32'hDEADBEEF.
//                          When undefined, wdog_err is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WDOG_LIMIT = 255
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    imem_req_valid,
    input  logic [ADDR_WIDTH-1:0]   imem_req_addr,
    output logic                    imem_resp_valid,
    output logic [DATA_WIDTH-1:0]   imem_resp_data,

    input  logic                    dmem_req_valid,
    input  logic                    dmem_req_rw,
    input  logic [ADDR_WIDTH-1:0]   dmem_req_addr,
    input  logic [DATA_WIDTH-1:0]   dmem_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] dmem_req_wmask,
    output logic                    dmem_resp_valid,
    output logic [DATA_WIDTH-1:0]   dmem_resp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,

    output logic                    stall,
    output logic                    wdog_err
);

    localparam int   c_MASK_W = DATA_WIDTH / 8;
    localparam logic c_IMEM   = 1'b0;
    localparam logic c_DMEM   = 1'b1;
    localparam logic [DATA_WIDTH-1:0] c_WDOG_DATA = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_MASK_W-1:0]   r_wmask;
    logic                  r_imem_resp_valid;
    logic [DATA_WIDTH-1:0] r_imem_resp_data;
    logic                  r_dmem_resp_valid;
    logic [DATA_WIDTH-1:0] r_dmem_resp_data;

    logic                  w_ireq;
    logic                  w_dreq;
    logic                  w_grant;
    logic                  w_grant_dmem;
    logic                  w_resp_fire;
    logic                  w_wdog_fire;
    logic                  w_timeout;

    // A requester keeps valid high during the cycle its response pulse is
    // visible; masking it here stops the same request being granted twice.
    assign w_ireq = imem_req_valid & ~r_imem_resp_valid;
    assign w_dreq = dmem_req_valid & ~r_dmem_resp_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_dmem = 1'b0;
        w_resp_fire  = 1'b0;
        w_wdog_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ireq || w_dreq) begin
                    w_grant = 1'b1;
                    // Round-robin on contention: favour the side not served last.
                    if (w_ireq && w_dreq) begin
                        w_grant_dmem = (r_last_grant == c_IMEM);
                    end else begin
                        w_grant_dmem = w_dreq;
                    end
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_wdog_fire = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_resp_fire = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_wdog_fire = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches and registered response paths
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner           <= c_IMEM;
            r_last_grant      <= c_IMEM;
            r_rw              <= 1'b0;
            r_addr            <= '0;
            r_wdata           <= '0;
            r_wmask           <= '0;
            r_imem_resp_valid <= 1'b0;
            r_imem_resp_data  <= '0;
            r_dmem_resp_valid <= 1'b0;
            r_dmem_resp_data  <= '0;
        end else begin
            r_imem_resp_valid <= 1'b0;
            r_dmem_resp_valid <= 1'b0;

            if (w_grant) begin
                r_owner      <= w_grant_dmem;
                r_last_grant <= w_grant_dmem;
                if (w_grant_dmem) begin
                    r_rw    <= dmem_req_rw;
                    r_addr  <= dmem_req_addr;
                    r_wdata <= dmem_req_wdata;
                    r_wmask <= dmem_req_wmask;
                end else begin
                    // Fetches are always reads with no write data/mask.
                    r_rw    <= 1'b0;
                    r_addr  <= imem_req_addr;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            end

            if (w_resp_fire) begin
                if (r_owner == c_DMEM) begin
                    r_dmem_resp_valid <= 1'b1;
                    r_dmem_resp_data  <= r_rw ? '0 : mem_resp_data;
                end else begin
                    r_imem_resp_valid <= 1'b1;
                    r_imem_resp_data  <= mem_resp_data;
                end
            end

            // Timeout releases the owner with a recognisable poison word.
            if (w_wdog_fire) begin
                if (r_owner == c_DMEM) begin
                    r_dmem_resp_valid <= 1'b1;
                    r_dmem_resp_data  <= c_WDOG_DATA;
                end else begin
                    r_imem_resp_valid <= 1'b1;
                    r_imem_resp_data  <= c_WDOG_DATA;
                end
            end
        end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int c_WCNT_W = ($clog2(WDOG_LIMIT + 1) > 8) ? $clog2(WDOG_LIMIT + 1) : 8;
    // The counter holds the number of cycles already spent in the current
    // state, so the limit is hit during the WDOG_LIMIT-th cycle.
    localparam logic [c_WCNT_W-1:0] c_WDOG_LAST = c_WCNT_W'(WDOG_LIMIT - 1);

    logic [c_WCNT_W-1:0] r_wdog_cnt;
    logic                r_wdog_err;

    assign w_timeout = (r_wdog_cnt == c_WDOG_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wdog_cnt <= '0;
            end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            if (w_wdog_fire) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;

    assign w_timeout     = 1'b0;
    assign wdog_err      = 1'b0;
    assign w_unused_wdog = (WDOG_LIMIT != 0);
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_valid   = (r_state == ST_REQ);
    assign mem_req_rw      = r_rw;
    assign mem_req_addr    = r_addr;
    assign mem_req_wdata   = r_wdata;
    assign mem_req_wmask   = r_wmask;

    assign imem_resp_valid = r_imem_resp_valid;
    assign imem_resp_data  = r_imem_resp_data;
    assign dmem_resp_valid = r_dmem_resp_valid;
    assign dmem_resp_data  = r_dmem_resp_data;

    assign stall = (imem_req_valid & ~r_imem_resp_valid) |
                   (dmem_req_valid & ~r_dmem_resp_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. The bench acts
//                as both the core (imem/dmem requesters) and the memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [DW-1:0] imem_resp_data;
    logic          dmem_req_valid;
    logic          dmem_req_rw;
    logic [AW-1:0] dmem_req_addr;
    logic [DW-1:0] dmem_req_wdata;
    logic [3:0]    dmem_req_wmask;
    logic          dmem_resp_valid;
    logic [DW-1:0] dmem_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [3:0]    mem_req_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          stall;
    logic          wdog_err;

    int n_pass  = 0;
    int n_total = 0;
    int wd_cycles;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WDOG_LIMIT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_rw     (dmem_req_rw),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wmask  (dmem_req_wmask),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_data  (dmem_resp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wmask   (mem_req_wmask),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .stall           (stall),
        .wdog_err        (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a falling edge with the request(s) already driven. Waits for
    // the grant, checks the memory-side fields, applies ready after
    // ready_delay stalled cycles, returns rdata one cycle later and checks
    // the registered response pulse. Drops the served requester afterwards.
    task automatic serve(input string tag, input bit exp_dmem,
                         input logic [31:0] exp_addr, input bit exp_rw,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                         input logic [31:0] rdata, input logic [31:0] exp_resp,
                         input int ready_delay);
        int  t;
        bit  exp_stall;
        t = 0;
        mem_req_ready = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while (mem_req_valid !== 1'b1 && t < 10);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, "_addr"},      64'(mem_req_addr),  64'(exp_addr));
        chk({tag, "_rw"},        64'(mem_req_rw),    64'(exp_rw));
        chk({tag, "_wdata"},     64'(mem_req_wdata), 64'(exp_wdata));
        chk({tag, "_wmask"},     64'(mem_req_wmask), 64'(exp_wmask));
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(mem_req_valid), 64'd1);
            chk({tag, "_hold_addr"},  64'(mem_req_addr),  64'(exp_addr));
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, "_wait_valid"}, 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        exp_stall = exp_dmem ? imem_req_valid : dmem_req_valid;
        chk({tag, "_ivalid"}, 64'(imem_resp_valid), 64'(!exp_dmem));
        chk({tag, "_dvalid"}, 64'(dmem_resp_valid), 64'(exp_dmem));
        if (exp_dmem) chk({tag, "_ddata"}, 64'(dmem_resp_data), 64'(exp_resp));
        else          chk({tag, "_idata"}, 64'(imem_resp_data), 64'(exp_resp));
        chk({tag, "_stall"}, 64'(stall), 64'(exp_stall));
        if (exp_dmem) dmem_req_valid = 1'b0;
        else          imem_req_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        dmem_req_valid = 1'b0;
        dmem_req_rw    = 1'b0;
        dmem_req_addr  = '0;
        dmem_req_wdata = '0;
        dmem_req_wmask = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        chk("rst_mem_req_valid", 64'(mem_req_valid),   64'd0);
        chk("rst_ivalid",        64'(imem_resp_valid), 64'd0);
        chk("rst_dvalid",        64'(dmem_resp_valid), 64'd0);
        chk("rst_addr",          64'(mem_req_addr),    64'd0);
        chk("rst_wmask",         64'(mem_req_wmask),   64'd0);
        chk("rst_stall",         64'(stall),           64'd0);
        chk("rst_wdog",          64'(wdog_err),        64'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- fetch only ----------------
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h200;
        #1 chk("fetch_stall_early", 64'(stall), 64'd1);
        serve("fetch", 1'b0, 32'h200, 1'b0, 32'h0, 4'h0, 32'h00000013, 32'h00000013, 0);
        @(negedge clk);
        chk("fetch_pulse_once", 64'(imem_resp_valid), 64'd0);
        chk("fetch_no_regrant", 64'(mem_req_valid),   64'd0);
        chk("fetch_stall_low",  64'(stall),           64'd0);

        // ---------------- simultaneous after reset ----------------
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h204;
        dmem_req_valid = 1'b1;
        dmem_req_rw    = 1'b0;
        dmem_req_addr  = 32'h1000;
        dmem_req_wdata = 32'h0;
        dmem_req_wmask = 4'h0;
        serve("both_d", 1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 32'h11111111, 32'h11111111, 0);
        serve("both_i", 1'b0, 32'h204,  1'b0, 32'h0, 4'h0, 32'h22222222, 32'h22222222, 0);

        // ---------------- store with back-pressure ----------------
        @(negedge clk);
        dmem_req_valid = 1'b1;
        dmem_req_rw    = 1'b1;
        dmem_req_addr  = 32'h1004;
        dmem_req_wdata = 32'hCAFEF00D;
        dmem_req_wmask = 4'b0011;
        serve("store", 1'b1, 32'h1004, 1'b1, 32'hCAFEF00D, 4'b0011, 32'hFFFFFFFF, 32'h0, 3);

        // ---------------- both pending, last grant was dmem -> imem first ----------------
        @(negedge clk);
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h208;
        dmem_req_valid = 1'b1;
        dmem_req_rw    = 1'b0;
        dmem_req_addr  = 32'h1008;
        dmem_req_wdata = 32'h0;
        dmem_req_wmask = 4'h0;
        serve("rr_i", 1'b0, 32'h208,  1'b0, 32'h0, 4'h0, 32'h33333333, 32'h33333333, 0);
        serve("rr_d", 1'b1, 32'h1008, 1'b0, 32'h0, 4'h0, 32'h44444444, 32'h44444444, 1);

        // ---------------- stray responses in IDLE and REQ ----------------
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55555555;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("stray_idle_ivalid", 64'(imem_resp_valid), 64'd0);
        chk("stray_idle_dvalid", 64'(dmem_resp_valid), 64'd0);
        chk("stray_idle_req",    64'(mem_req_valid),   64'd0);
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h300;
        mem_req_ready  = 1'b0;
        @(negedge clk);
        chk("stray_req_state", 64'(mem_req_valid), 64'd1);
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        chk("stray_req_ivalid", 64'(imem_resp_valid), 64'd0);
        chk("stray_req_hold",   64'(mem_req_valid),   64'd1);
        serve("bp", 1'b0, 32'h300, 1'b0, 32'h0, 4'h0, 32'h66666666, 32'h66666666, 0);

        // ---------------- reset while in WAIT ----------------
        @(negedge clk);
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h400;
        @(negedge clk);
        chk("rw_req", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_wait", 64'(mem_req_valid), 64'd0);
        reset = 1'b0;
        imem_req_valid = 1'b0;
        #1;
        chk("rw_addr_cleared", 64'(mem_req_addr), 64'd0);
        chk("rw_stall",        64'(stall),        64'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h77777777;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        chk("rw_ivalid",  64'(imem_resp_valid), 64'd0);
        chk("rw_dvalid",  64'(dmem_resp_valid), 64'd0);
        chk("rw_idle",    64'(mem_req_valid),   64'd0);
        chk("rw_idata",   64'(imem_resp_data),  64'd0);
        chk("rw_addr",    64'(mem_req_addr),    64'd0);

`ifdef MEM_ARB_WATCHDOG_EN
        // ---------------- watchdog: memory never responds ----------------
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h500;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        chk("wd_req", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wd_wait", 64'(mem_req_valid), 64'd0);
        wd_cycles = 0;
        while (imem_resp_valid !== 1'b1 && wd_cycles < 40) begin
            @(negedge clk);
            wd_cycles++;
        end
        chk("wd_cycles", 64'(wd_cycles),      64'd16);
        chk("wd_data",   64'(imem_resp_data), 64'hDEADBEEF);
        chk("wd_err",    64'(wdog_err),       64'd1);
        imem_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wd_err_sticky", 64'(wdog_err),        64'd1);
        chk("wd_pulse_once", 64'(imem_resp_valid), 64'd0);
`else
        chk("wdog_tied_low", 64'(wdog_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
